// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: one outstanding imem request feeding a DEPTH-entry FIFO toward decode.
// Optional same-cycle response bypass to decode when the queue is empty: define IF_FETCH_BYPASS_EN.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  output logic        busy_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pend_pc_q;
  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [XLEN-1:0]   instr_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic req;
  logic rsp_ok;
  logic push;
  logic pop;
  logic q_empty;
  logic q_full;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CNT_W'(DEPTH));
  assign rsp_ok  = (state_q == ST_WAIT) && imem_rvalid_i && !flush_i;

  // Next-state and request strobe; request gated by reset so it is low while rst_ni is held
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst_ni && !q_full && !flush_i) begin
          req     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_IDLE;
        end else if (flush_i) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // Once the abandoned response arrives nothing is in flight, even under a new flush
        if (imem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (req) begin
        pend_pc_q <= pc_i;
      end
    end
  end

  assign imem_req_o  = req;
  assign busy_o      = !req;
  assign imem_addr_o = pc_i;

  assign pop = !q_empty && !flush_i && id_ready_i;

`ifdef IF_FETCH_BYPASS_EN
  logic byp;

  // Response goes straight to decode when nothing is queued ahead of it
  assign byp        = q_empty && rsp_ok;
  assign push       = rsp_ok && !(byp && id_ready_i);
  assign id_valid_o = byp || (!q_empty && !flush_i);
  assign id_instr_o = byp ? imem_rdata_i : instr_mem_q[rd_ptr_q];
  assign id_pc_o    = byp ? pend_pc_q    : pc_mem_q[rd_ptr_q];
`else
  assign push       = rsp_ok;
  assign id_valid_o = !q_empty && !flush_i;
  assign id_instr_o = instr_mem_q[rd_ptr_q];
  assign id_pc_o    = pc_mem_q[rd_ptr_q];
`endif

  // Queue storage, pointers and occupancy; flush empties the queue at the next edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= pend_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_rdata_i;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Space is reserved when the request issues, so a push into a full queue is a design bug
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && q_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=2); expectations follow IF_FETCH_BYPASS_EN.
module tb_if_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        busy_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  bit          byp;

  if_fetch_queue #(.DEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pc_i         (pc_i),
    .busy_o       (busy_o),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_ready_i   (id_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    imem_rvalid_i = 1'b0;
    #1;
    tick();
    rst_ni = 1'b1;
  endtask

  // IDLE cycle: a request for pc must be presented, then the edge moves the FSM to WAIT
  task automatic issue(input logic [31:0] pc);
    pc_i          = pc;
    imem_rvalid_i = 1'b0;
    #1;
    check("req", 32'(imem_req_o), 32'd1);
    check("busy", 32'(busy_o), 32'd0);
    check("addr", imem_addr_o, pc);
    tick();
  endtask

  // WAIT cycle with the response; empty = queue held nothing before this push
  task automatic respond(input logic [31:0] pc, input logic [31:0] instr, input bit empty);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = instr;
    #1;
    check("wait_req", 32'(imem_req_o), 32'd0);
    check("wait_busy", 32'(busy_o), 32'd1);
    if (empty) begin
      check("same_cyc_valid", 32'(id_valid_o), 32'(byp));
      if (byp) begin
        check("byp_pc", id_pc_o, pc);
        check("byp_instr", id_instr_o, instr);
      end
    end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    if (empty) begin
      if (!byp || !id_ready_i) begin
        check("next_valid", 32'(id_valid_o), 32'd1);
        check("next_pc", id_pc_o, pc);
        check("next_instr", id_instr_o, instr);
      end else begin
        check("byp_consumed", 32'(id_valid_o), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] stream_instr [3];
    stream_instr[0] = 32'h0000_0093;
    stream_instr[1] = 32'h0010_8113;
    stream_instr[2] = 32'h0021_0193;
`ifdef IF_FETCH_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst_ni        = 1'b0;
    pc_i          = 32'h0;
    flush_i       = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    id_ready_i    = 1'b1;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_valid", 32'(id_valid_o), 32'd0);
    check("rst_instr", id_instr_o, 32'h0);
    check("rst_pc", id_pc_o, 32'h0);
    tick();
    rst_ni = 1'b1;

    // Streaming fetch with decode always ready
    for (int k = 0; k < 3; k++) begin
      issue(32'(4 * k));
      respond(32'(4 * k), stream_instr[k], 1'b1);
    end

    // Decode stall fills the two-entry queue and blocks further requests
    do_reset();
    id_ready_i = 1'b0;
    issue(32'h40);
    respond(32'h40, 32'h1111_1111, 1'b1);
    issue(32'h44);
    respond(32'h44, 32'h2222_2222, 1'b0);
    pc_i = 32'h48;
    #1;
    check("full_req", 32'(imem_req_o), 32'd0);
    check("full_busy", 32'(busy_o), 32'd1);
    check("full_valid", 32'(id_valid_o), 32'd1);
    check("full_pc", id_pc_o, 32'h40);
    check("full_instr", id_instr_o, 32'h1111_1111);
    tick();
    check("hold_pc", id_pc_o, 32'h40);
    check("hold_instr", id_instr_o, 32'h1111_1111);
    check("hold_req", 32'(imem_req_o), 32'd0);
    id_ready_i = 1'b1;
    #1;
    check("full_req2", 32'(imem_req_o), 32'd0);
    tick();
    check("resume_req", 32'(imem_req_o), 32'd1);
    check("resume_addr", imem_addr_o, 32'h48);
    check("resume_pc", id_pc_o, 32'h44);
    check("resume_instr", id_instr_o, 32'h2222_2222);

    // Flush while waiting: the late response is dropped, redirect target fetched next
    do_reset();
    id_ready_i = 1'b1;
    issue(32'h10);
    flush_i = 1'b1;
    pc_i    = 32'h100;
    #1;
    check("flw_req", 32'(imem_req_o), 32'd0);
    check("flw_busy", 32'(busy_o), 32'd1);
    tick();
    flush_i       = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check("drop_valid", 32'(id_valid_o), 32'd0);
    check("drop_req", 32'(imem_req_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("drop_after_valid", 32'(id_valid_o), 32'd0);
    issue(32'h100);
    respond(32'h100, 32'h0000_0513, 1'b1);

    // Flush coinciding with the response
    do_reset();
    issue(32'h200);
    flush_i       = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAAD_F00D;
    pc_i          = 32'h300;
    #1;
    check("flr_valid", 32'(id_valid_o), 32'd0);
    check("flr_req", 32'(imem_req_o), 32'd0);
    tick();
    flush_i       = 1'b0;
    imem_rvalid_i = 1'b0;
    #1;
    check("flr_after_valid", 32'(id_valid_o), 32'd0);
    issue(32'h300);
    respond(32'h300, 32'h0000_0593, 1'b1);

    // Asynchronous reset in the middle of an outstanding request
    do_reset();
    id_ready_i = 1'b0;
    issue(32'h500);
    respond(32'h500, 32'h3333_3333, 1'b1);
    issue(32'h504);
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(id_valid_o), 32'd0);
    check("arst_instr", id_instr_o, 32'h0);
    check("arst_pc", id_pc_o, 32'h0);
    check("arst_req", 32'(imem_req_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd1);
    tick();
    pc_i          = 32'h600;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h4444_4444;
    rst_ni        = 1'b1;
    #1;
    check("post_rst_req", 32'(imem_req_o), 32'd1);
    check("post_rst_addr", imem_addr_o, 32'h600);
    check("post_rst_valid", 32'(id_valid_o), 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    check("stale_no_push", 32'(id_valid_o), 32'd0);
    respond(32'h600, 32'h5555_5555, 1'b1);

    // Single fetch into an empty queue: bypass timing vs registered timing
    do_reset();
    id_ready_i = 1'b1;
    issue(32'h20);
    respond(32'h20, 32'h0000_0013, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter: DEPTH, 2, instruction queue entries; power of two, 2..8.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-004 pc_i  in  32  current PC from program counter register.
REQ-005 busy_o  out  1  to PC register busy input; low only in a cycle where pc_i is being fetched (PC may advance).
REQ-006 flush_i  in  1  branch/jump redirect; discard queued and in-flight instructions.
REQ-007 imem_req_o  out  1  single-cycle fetch request strobe.
REQ-008 imem_addr_o  out  32  fetch address, equals pc_i when imem_req_o=1.
REQ-009 imem_rvalid_i  in  1  response valid; at least 1 cycle after request.
REQ-010 imem_rdata_i  in  32  fetched instruction word.
REQ-011 id_valid_o  out  1  queue head valid toward decode.
REQ-012 id_instr_o  out  32  head instruction.
REQ-013 id_pc_o  out  32  PC of head instruction.
REQ-014 id_ready_i  in  1  decode accepts head (low = pipeline stall).

Function
REQ-015 FSM states IDLE, WAIT, DROP; at most one outstanding memory request.
REQ-016 IDLE: imem_req_o=1 iff count<DEPTH and flush_i=0; on request, latch pc_i as pending PC, go WAIT.
REQ-017 busy_o SHALL equal the inverse of imem_req_o (combinational).
REQ-018 WAIT: on imem_rvalid_i, push {pending PC, imem_rdata_i} at tail, go IDLE; no new request that cycle.
REQ-019 Pop when id_valid_o and id_ready_i; push and pop in same cycle keep count unchanged.
REQ-020 Overflow impossible: requests issued only with reserved space; push when full is a design error (assertion).
REQ-021 Without bypass, pushed entry appears on id_* the cycle after imem_rvalid_i (1-cycle latency).
REQ-022 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-023 flush_i: queue count, pointers cleared at next edge; id_valid_o forced 0 while flush_i=1.
REQ-024 flush_i in WAIT without imem_rvalid_i: go DROP; DROP discards next response, then IDLE.
REQ-025 flush_i in WAIT with imem_rvalid_i same cycle: response discarded, go IDLE.
REQ-026 flush_i in DROP: stay DROP; imem_rvalid_i in DROP never pushes.
REQ-027 id_instr_o/id_pc_o hold value while id_valid_o=1 and id_ready_i=0.

Reset
REQ-028 rst_ni=0 immediately forces: state IDLE, count 0, pointers 0, imem_req_o 0, busy_o 1, id_valid_o 0, id_instr_o 0, id_pc_o 0.
REQ-029 Reset mid-WAIT abandons request; first request issued in first clock edge cycle after rst_ni rises.

Configuration
REQ-030 Macro IF_FETCH_BYPASS_EN: defined, when queue empty and imem_rvalid_i (not discarded), id_valid_o/id_instr_o/id_pc_o driven combinationally from response same cycle; if id_ready_i=1 entry not stored.
REQ-031 Not defined: no bypass path; latency per REQ-021; all id_* outputs registered from queue.

Verification
REQ-032 Reset: rst_ni=0 mid-WAIT -> all outputs zero, busy_o=1 asynchronously, no push on later rvalid.
REQ-033 Streaming: pc_i 0x0,0x4,0x8, 1-cycle memory, id_ready_i=1 -> id_pc_o sequence 0x0,0x4,0x8 with matching instructions, busy_o low once per fetch.
REQ-034 Stall: id_ready_i=0, DEPTH=2 -> after two entries imem_req_o stays 0, busy_o=1; id_ready_i=1 resumes at next PC.
REQ-035 Flush in WAIT: request 0x10, flush_i before rvalid, redirect pc_i=0x100 -> 0x10 response dropped, next id_pc_o=0x100.
REQ-036 Flush with rvalid same cycle -> response discarded, FSM IDLE next cycle, request issued cycle after.
REQ-037 Bypass (macro on): empty queue, rvalid with 0x00000013 at PC 0x20 -> id_valid_o=1, id_instr_o=0x00000013 same cycle; macro off -> one cycle later.
